// File: rtl/note_fetch_pkg.sv
// Shared types and helpers for the note fetch sequencer: FSM states, ROM word layout, address forming.
package note_fetch_pkg;

    localparam int NF_NUM_CH    = 3;
    localparam int NF_CH_ADDR_W = 6;
    localparam int NF_DATA_W    = 16;

    localparam int END_BIT = NF_DATA_W - 1;
    localparam logic [NF_DATA_W-2:0] REST = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_DELIVER
    } fetch_state_e;

    function automatic logic [NF_CH_ADDR_W+1:0] rom_addr(
        input logic [1:0]              ch,
        input logic [NF_CH_ADDR_W-1:0] ptr
    );
        return {ch, ptr};
    endfunction

endpackage

// File: rtl/note_fetch_ptr_bank.sv
// Per-channel song pointers and halt flags; the selected channel's pointer/halt are read combinationally,
// updates (increment, clear, halt) apply to the selected channel at the next clock.
module note_fetch_ptr_bank
    import note_fetch_pkg::*;
#(
    parameter int NUM_CH    = NF_NUM_CH,
    parameter int CH_ADDR_W = NF_CH_ADDR_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           sel_i,
    input  logic                 inc_i,
    input  logic                 clr_i,
    input  logic                 halt_set_i,
    output logic [CH_ADDR_W-1:0] ptr_o,
    output logic                 halt_o
);

    logic [CH_ADDR_W-1:0] ptr_q [NUM_CH];
    logic [CH_ADDR_W-1:0] ptr_d [NUM_CH];
    logic [NUM_CH-1:0]    halt_q;
    logic [NUM_CH-1:0]    halt_d;

    always_comb begin
        halt_d = halt_q;
        for (int c = 0; c < NUM_CH; c++) begin
            ptr_d[c] = ptr_q[c];
            if (sel_i == 2'(c)) begin
                // Clear wins over increment; the pointer wraps silently at the region end.
                if (clr_i) begin
                    ptr_d[c] = '0;
                end else if (inc_i) begin
                    ptr_d[c] = ptr_q[c] + CH_ADDR_W'(1);
                end
                if (halt_set_i) begin
                    halt_d[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ptr_q[c] <= '0;
            end
            halt_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                ptr_q[c] <= ptr_d[c];
            end
            halt_q <= halt_d;
        end
    end

    always_comb begin
        ptr_o  = '0;
        halt_o = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel_i == 2'(c)) begin
                ptr_o  = ptr_q[c];
                halt_o = halt_q[c];
            end
        end
    end

endmodule

// File: rtl/note_fetch_scheduler.sv
// Per beat, fetches one note word per channel (ch0..ch2) from the shared ROM; ch0 valid 3 cycles after the beat, 3 cycles per channel.
// Beats during a round are pended one-deep, further ones pulse o_overrun. NOTE_FETCH_SONG_LOOP_EN: end marker rewinds instead of halting.
module note_fetch_scheduler
    import note_fetch_pkg::*;
#(
    parameter int NUM_CH    = NF_NUM_CH,
    parameter int CH_ADDR_W = NF_CH_ADDR_W,
    parameter int DATA_W    = NF_DATA_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_beat_stb,
    input  logic                   i_enable,
    output logic                   o_rom_rd,
    output logic [CH_ADDR_W+1:0]   o_rom_addr,
    input  logic [DATA_W-1:0]      i_rom_data,
    output logic [DATA_W-2:0]      o_note,
    output logic [NUM_CH-1:0]      o_note_valid,
    output logic [NUM_CH-1:0]      o_end_stb,
    output logic                   o_busy,
    output logic                   o_overrun
);

    fetch_state_e         state_q, state_d;
    logic [1:0]           cur_q, cur_d;
    logic                 pending_q, pending_d;
    logic [DATA_W-2:0]    note_q, note_d;
    logic                 beat_acc;
    logic                 ptr_inc, ptr_clr, halt_set;
    logic [CH_ADDR_W-1:0] cur_ptr;
    logic                 halted;
    logic [NUM_CH-1:0]    cur_oh;
    logic                 rom_rd;
    logic [NUM_CH-1:0]    end_stb;
    logic [NUM_CH-1:0]    note_valid;
    logic                 overrun;
`ifdef NOTE_FETCH_SONG_LOOP_EN
    logic                 reread_q, reread_d;
`endif

    assign beat_acc = i_beat_stb & i_enable;
    assign cur_oh   = NUM_CH'(1) << cur_q;

    note_fetch_ptr_bank #(
        .NUM_CH    (NUM_CH),
        .CH_ADDR_W (CH_ADDR_W)
    ) u_ptr_bank (
        .clk_i      (i_clk),
        .rst_ni     (i_rst_n),
        .sel_i      (cur_q),
        .inc_i      (ptr_inc),
        .clr_i      (ptr_clr),
        .halt_set_i (halt_set),
        .ptr_o      (cur_ptr),
        .halt_o     (halted)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        pending_d  = pending_q;
        note_d     = note_q;
        rom_rd     = 1'b0;
        end_stb    = '0;
        note_valid = '0;
        overrun    = 1'b0;
        ptr_inc    = 1'b0;
        ptr_clr    = 1'b0;
        halt_set   = 1'b0;
`ifdef NOTE_FETCH_SONG_LOOP_EN
        reread_d   = reread_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (beat_acc || pending_q) begin
                    state_d   = ST_ISSUE;
                    cur_d     = '0;
                    pending_d = 1'b0;
                    overrun   = beat_acc && pending_q;
                end
            end
            ST_ISSUE: begin
                rom_rd  = !halted;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_DELIVER;
                if (halted) begin
                    note_d = REST;
                end else if (!i_rom_data[END_BIT]) begin
                    note_d  = i_rom_data[DATA_W-2:0];
                    ptr_inc = 1'b1;
                end else begin
                    end_stb = cur_oh;
                    note_d  = REST;
`ifdef NOTE_FETCH_SONG_LOOP_EN
                    ptr_clr = 1'b1;
                    if (!reread_q) begin
                        reread_d = 1'b1;
                        state_d  = ST_ISSUE;
                    end
`else
                    halt_set = 1'b1;
`endif
                end
            end
            ST_DELIVER: begin
                note_valid = cur_oh;
`ifdef NOTE_FETCH_SONG_LOOP_EN
                reread_d   = 1'b0;
`endif
                if (cur_q == 2'(NUM_CH - 1)) begin
                    // A pended beat chains straight into the next round without an idle cycle.
                    if (pending_q) begin
                        state_d   = ST_ISSUE;
                        cur_d     = '0;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cur_d   = cur_q + 2'd1;
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (beat_acc && state_q != ST_IDLE) begin
            if (pending_q) begin
                overrun = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            pending_q <= 1'b0;
            note_q    <= '0;
`ifdef NOTE_FETCH_SONG_LOOP_EN
            reread_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            pending_q <= pending_d;
            note_q    <= note_d;
`ifdef NOTE_FETCH_SONG_LOOP_EN
            reread_q  <= reread_d;
`endif
        end
    end

    assign o_rom_rd     = rom_rd;
    assign o_rom_addr   = rom_rd ? rom_addr(cur_q, cur_ptr) : '0;
    assign o_note       = (state_q == ST_DELIVER) ? note_q : '0;
    assign o_note_valid = note_valid;
    assign o_end_stb    = end_stb;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_overrun    = overrun;

endmodule

// File: tb/tb_note_fetch_scheduler.sv
// Bench for note_fetch_scheduler: ROM model, delivery scoreboard, timing checks against the beat cycle.
module tb_note_fetch_scheduler;

`ifdef NOTE_FETCH_SONG_LOOP_EN
    localparam int LE = 2;
    localparam int END2 = 2;
    localparam int RD2 = 4;
`else
    localparam int LE = 0;
    localparam int END2 = 1;
    localparam int RD2 = 1;
`endif

    logic        i_clk;
    logic        i_rst_n;
    logic        i_beat_stb;
    logic        i_enable;
    logic        o_rom_rd;
    logic [7:0]  o_rom_addr;
    logic [15:0] i_rom_data;
    logic [14:0] o_note;
    logic [2:0]  o_note_valid;
    logic [2:0]  o_end_stb;
    logic        o_busy;
    logic        o_overrun;

    note_fetch_scheduler dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_beat_stb   (i_beat_stb),
        .i_enable     (i_enable),
        .o_rom_rd     (o_rom_rd),
        .o_rom_addr   (o_rom_addr),
        .i_rom_data   (i_rom_data),
        .o_note       (o_note),
        .o_note_valid (o_note_valid),
        .o_end_stb    (o_end_stb),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun)
    );

    typedef struct {
        logic [2:0]  oh;
        logic [14:0] note;
    } exp_t;

    logic [15:0] mem [256];
    logic [5:0]  m_ptr [3];
    logic        m_halt [3];
    exp_t        sb [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_end2 = 0;
    int n_ovr = 0;
    int n_busy = 0;
    int n_rd = 0;
    int n_rd2 = 0;
    int v2_cyc [$];
    int rd0_cyc [$];
    logic [7:0] rd0_addr [$];
    logic [7:0] rd_addr [$];

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(posedge i_clk) begin
        if (o_rom_rd) i_rom_data <= mem[o_rom_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_rom_rd) begin
            n_rd++;
            rd_addr.push_back(o_rom_addr);
            if (o_rom_addr[7:6] == 2'd0) begin
                rd0_cyc.push_back(cyc);
                rd0_addr.push_back(o_rom_addr);
            end
            if (o_rom_addr[7:6] == 2'd2) n_rd2++;
        end
        if (o_note_valid != 3'b000) begin
            n_valid++;
            if (o_note_valid[2]) v2_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("sb_unexpected_delivery", {29'd0, o_note_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("note_channel", {29'd0, o_note_valid}, {29'd0, e.oh});
                check("note_data", {17'd0, o_note}, {17'd0, e.note});
            end
        end
        if (o_end_stb[2]) n_end2++;
        if (o_overrun) n_ovr++;
        if (o_busy) n_busy++;
    end

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_ptr[c] = 6'd0;
            m_halt[c] = 1'b0;
        end
    endtask

    task automatic model_ch(input int c);
        exp_t e;
        logic [15:0] w;
        e.oh = 3'b001 << c;
        e.note = 15'd0;
        if (!m_halt[c]) begin
            w = mem[c * 64 + int'(m_ptr[c])];
            if (!w[15]) begin
                e.note = w[14:0];
                m_ptr[c] = m_ptr[c] + 6'd1;
            end else begin
`ifdef NOTE_FETCH_SONG_LOOP_EN
                m_ptr[c] = 6'd0;
                w = mem[c * 64];
                if (!w[15]) begin
                    e.note = w[14:0];
                    m_ptr[c] = 6'd1;
                end
`else
                m_halt[c] = 1'b1;
`endif
            end
        end
        sb.push_back(e);
    endtask

    task automatic model_round();
        for (int c = 0; c < 3; c++) model_ch(c);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic pulse_beat();
        i_beat_stb = 1'b1;
        tick(1);
        i_beat_stb = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (o_busy && n < 200) begin
            tick(1);
            n++;
        end
        check("idle_within_bound", {31'd0, n < 200}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, nv, e2, ovr, rd, rd2, bz;
        for (int a = 0; a < 256; a++) mem[a] = 16'h0002;
        for (int i = 0; i < 64; i++) begin
            mem[i]      = 16'h0100 + 16'(i);
            mem[64 + i] = 16'h0400 + 16'(i);
        end
        mem[0]    = 16'h0123;
        mem[64]   = 16'h0456;
        mem[128]  = 16'h0001;
        mem[129]  = 16'h8000;
        model_reset();

        i_rst_n = 1'b0;
        i_beat_stb = 1'b0;
        i_enable = 1'b1;
        tick(3);
        @(negedge i_clk);
        check("reset_outputs", {o_rom_rd, o_rom_addr, o_note, o_note_valid, o_end_stb, o_busy, o_overrun}, 32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        tick(2);

        // Round 1: latency of each stage relative to the beat cycle.
        i_beat_stb = 1'b1;
        model_round();
        @(negedge i_clk);
        check("busy_before_start", {31'd0, o_busy}, 32'd0);
        @(posedge i_clk);
        #1;
        i_beat_stb = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge i_clk);
            case (k)
                1: begin
                    check("t1_rom_rd", {31'd0, o_rom_rd}, 32'd1);
                    check("t1_rom_addr", {24'd0, o_rom_addr}, 32'h00);
                    check("t1_busy", {31'd0, o_busy}, 32'd1);
                end
                3: begin
                    check("t3_valid", {29'd0, o_note_valid}, 32'b001);
                    check("t3_note", {17'd0, o_note}, 32'h123);
                end
                4: check("t4_rom_addr", {24'd0, o_rom_addr}, 32'h40);
                6: begin
                    check("t6_valid", {29'd0, o_note_valid}, 32'b010);
                    check("t6_note", {17'd0, o_note}, 32'h456);
                end
                9: check("t9_valid", {29'd0, o_note_valid}, 32'b100);
                10: check("t10_busy", {31'd0, o_busy}, 32'd0);
                default: ;
            endcase
        end
        tick(1);

        // Rounds 2-3: pended beat, dropped third beat, ch2 end marker.
        v2_cyc.delete();
        rd0_cyc.delete();
        nv = n_valid; e2 = n_end2; ovr = n_ovr; rd2 = n_rd2;
        t0 = cyc;
        model_round();
        pulse_beat();
        tick(3);
        model_round();
        pulse_beat();
        tick(1);
        pulse_beat();
        wait_idle();
        tick(2);
        check("overrun_count", n_ovr - ovr, 32'd1);
        check("two_rounds_delivered", n_valid - nv, 32'd6);
        check("ch2_valid_latency", v2_cyc.size() > 0 ? v2_cyc[0] - t0 : -1, 9 + LE);
        check("round2_start", rd0_cyc.size() > 1 ? rd0_cyc[1] - t0 : -1, 10 + LE);
        check("ch2_end_stb_count", n_end2 - e2, END2);
        check("ch2_rom_reads", n_rd2 - rd2, RD2);

        // Disabled beat is ignored; disabling mid-round does not cut the round short.
        rd = n_rd; bz = n_busy;
        i_enable = 1'b0;
        pulse_beat();
        tick(12);
        check("disabled_no_read", n_rd - rd, 32'd0);
        check("disabled_no_busy", n_busy - bz, 32'd0);
        i_enable = 1'b1;
        nv = n_valid;
        model_round();
        pulse_beat();
        tick(1);
        i_enable = 1'b0;
        wait_idle();
        tick(2);
        check("enable_drop_deliveries", n_valid - nv, 32'd3);
        i_enable = 1'b1;

        // Reset mid-round: only ch0 gets delivered before the abort.
        model_ch(0);
        pulse_beat();
        tick(4);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("post_reset_outputs", {o_rom_rd, o_rom_addr, o_note, o_note_valid, o_end_stb, o_busy, o_overrun}, 32'd0);
        check("sb_drained_at_reset", sb.size(), 32'd0);
        @(posedge i_clk);
        #1;
        model_reset();
        rd_addr.delete();
        model_round();
        pulse_beat();
        wait_idle();
        tick(2);
        check("post_reset_reads", rd_addr.size(), 32'd3);
        check("post_reset_addr0", rd_addr.size() > 0 ? {24'd0, rd_addr[0]} : 32'hFFFF, 32'h00);
        check("post_reset_addr1", rd_addr.size() > 1 ? {24'd0, rd_addr[1]} : 32'hFFFF, 32'h40);
        check("post_reset_addr2", rd_addr.size() > 2 ? {24'd0, rd_addr[2]} : 32'hFFFF, 32'h80);

        // Pointer wrap: 65 rounds from reset, the 65th ch0 fetch is back at 0x00.
        i_rst_n = 1'b0;
        tick(2);
        i_rst_n = 1'b1;
        tick(1);
        model_reset();
        rd0_addr.delete();
        for (int i = 0; i < 65; i++) begin
            model_round();
            pulse_beat();
            wait_idle();
            tick(1);
        end
        tick(2);
        check("wrap_read_count", rd0_addr.size(), 32'd65);
        check("wrap_addr_63", rd0_addr.size() > 63 ? {24'd0, rd0_addr[63]} : 32'hFFFF, 32'h3F);
        check("wrap_addr_64", rd0_addr.size() > 64 ? {24'd0, rd0_addr[64]} : 32'hFFFF, 32'h00);

        check("sb_empty_at_end", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/note_fetch_scheduler.md
Name: note_fetch_scheduler

Overview:
- Sequencer that feeds note words to the three voice channels (pulse 1, pulse 2, triangle) from one shared synchronous song ROM.
- On each beat strobe it runs one fetch round: a fixed-order pass ch0→ch1→ch2 that reads each channel's next note word and delivers it with a one-hot valid strobe.
- Sits between timing_strobe_generator and the channel blocks; owns all per-channel song pointers.

Parameters:
- NUM_CH, 3, number of channels; fixed at 3 in this revision.
- CH_ADDR_W, 6, per-channel pointer width; each channel owns a 2^CH_ADDR_W-word ROM region.
- DATA_W, 16, ROM word width; bit DATA_W-1 = end marker, low DATA_W-1 bits = note data.

Ports:
- i_clk  in  1  system clock (48 kHz sample clock domain).
- i_rst_n  in  1  reset, synchronous, active-low.
- i_beat_stb  in  1  one-cycle strobe; starts a fetch round.
- i_enable  in  1  when low, new beats are ignored; a round already in progress still completes.
- o_rom_rd  out  1  ROM read enable; ROM data is valid the cycle after.
- o_rom_addr  out  2+CH_ADDR_W  read address = {channel index[1:0], channel pointer}.
- i_rom_data  in  DATA_W  ROM read data.
- o_note  out  DATA_W-1  delivered note data; shared bus for all channels.
- o_note_valid  out  NUM_CH  one-hot; bit c high for one cycle when o_note is for channel c.
- o_end_stb  out  NUM_CH  one-cycle pulse when channel c reads its end marker.
- o_busy  out  1  high while a round is in progress.
- o_overrun  out  1  one-cycle pulse when a beat is dropped.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low.
- Reset values: every output 0; all pointers 0; FSM in IDLE; pending flag 0; halt flags 0. Reset asserted mid-round aborts the round immediately, with no partial delivery.
- FSM states: IDLE, ISSUE, CAPTURE, DELIVER. Channel index cur runs 0..2.
- IDLE: if i_beat_stb && i_enable, or pending is set, go to ISSUE with cur=0 and clear pending.
- ISSUE: o_rom_rd=1, o_rom_addr={cur, ptr[cur]}; go to CAPTURE.
- CAPTURE: register i_rom_data.
  - If the end marker is clear: store the note and increment ptr[cur]. CH_ADDR_W wrap at the region end is silent (0x3F→0x00).
  - If the end marker is set: apply the end-marker rule below.
  - Go to DELIVER.
- DELIVER: o_note and o_note_valid[cur] are high for exactly this cycle. If cur==2 go to IDLE, else cur+1 and go to ISSUE.
- Latency: the beat is sampled at cycle T.
  - ch0 valid at T+3, ch1 at T+6, ch2 at T+9.
  - o_busy is high from T+1 through T+9 inclusive.
- Beat during busy: set pending (one-deep). The next round starts the cycle after DELIVER of ch2. A beat arriving while pending is already set is dropped and pulses o_overrun.
- Beat coinciding with ch2 DELIVER: counts as during busy, so it is pended.
- End-marker rule:
  - o_end_stb[cur] pulses in the CAPTURE cycle.
  - The note data is discarded.
  - Delivery for that channel follows the Optional Feature behaviour.
- Halted channel: no ROM read is issued. ISSUE and CAPTURE still take their cycles, so round timing stays fixed. o_note=0 (rest) and valid still pulses.

Optional Feature:
- Macro: NOTE_FETCH_SONG_LOOP_EN.
- Defined: on an end marker, set ptr[cur]=0 and return to ISSUE once to re-read address {cur,0}; channel latency grows by 2 cycles.
  - If the re-read word is also an end marker, deliver rest (0).
  - At most one re-read per channel per round.
- Undefined: on an end marker, set halt[cur]. The channel delivers rest (0) every round until reset.

Decomposition:
- Package note_fetch_pkg holds:
  - FSM state enum.
  - END_BIT index constant.
  - REST note constant (0).
  - Address-forming helper function.
- One natural sub-module: note_fetch_ptr_bank, holding the per-channel pointers and halt flags, with increment/clear ports.
- The FSM stays in the top module.

Test Plan:
- Reset with ROM word at ch0 addr0 = 0x0123 and at ch1 addr0 = 0x0456, then beat at T → o_rom_addr 0x00 at T+1, o_note=0x123 with valid=001 at T+3; o_rom_addr 0x40 at T+4, 0x456 with valid=010 at T+6; valid=100 at T+9; o_busy low at T+10.
- Two beats 4 cycles apart → second round starts at T+10, 0 overrun; a third beat during the same round → o_overrun pulses once, and only 2 rounds are delivered in total.
- ch2 region: words 0x0001, then 0x8000 at addr1 → o_end_stb[2] pulses in round 2. With NOTE_FETCH_SONG_LOOP_EN, round 2 ch2 delivers 0x0001 and ch2 valid lands at T+11. Without it, rounds 2 and 3 deliver 0 and no further ROM reads are issued for ch2.
- i_enable=0 with beat → no o_rom_rd, o_busy stays 0. Dropping i_enable mid-round → the round still completes all 3 deliveries.
- i_rst_n low for 1 cycle at T+5 → all outputs 0 at T+6; the next beat reads from addr 0 for every channel.
- Pointer wrap: 64 non-end words in ch0 and 65 beats → the 65th ch0 fetch reads address 0x00 again.
